// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl
// Register-file access sequencer for a 4 x DATA_W register file. Accepts one
// 8-bit instruction {op[7:6], rs[5:4], rt[3:2], rd[1:0]}, reads the operands,
// runs one ALU op and issues exactly one write-back.
//
// Handshake: an instruction transfers on a rising clk edge where
// instr_valid && instr_ready. instr_ready is high only in IDLE, so an
// instruction presented while busy stays pending and is not consumed.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   instr, instr_valid    instruction input and its valid
//   instr_ready           high only in IDLE
//   rf_raddr1/2           read addresses (rs/rt), updated only for ALU ops
//   rf_rdata1/2           combinational read data from the register file
//   rf_write, rf_waddr,   registered write port; rf_write is high for the
//   rf_wdata              whole WRITE cycle, address/data held otherwise
//   done                  one-cycle pulse coincident with rf_write
//   busy                  high in any state other than IDLE
//   fsm_state             current FSM state, for observation
//   flag_z, flag_c        only when REGCTL_FLAGS_EN is defined; updated at
//                         the end of WRITE
//
// Optional feature macro: REGCTL_FLAGS_EN (zero/carry flags).
module regfile_seq_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [1:0]        rf_raddr1,
  output logic [1:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_write,
  output logic [1:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              busy,
  output logic [1:0]        fsm_state
`ifdef REGCTL_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_LI   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [1:0]        op_q;
  logic [3:0]        imm_q;     // instr[5:2], the LI immediate
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] alu_result;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) state_next = (instr[7:6] == OP_LI) ? EXEC : READ;
      end
      READ:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fsm_state = state;
  assign rf_wdata  = result_q;

  // ALU; LI sign-extends the 4-bit immediate
  always_comb begin
    alu_result = '0;
    case (op_q)
      OP_ADD:  alu_result = opa_q + opb_q;
      OP_SUB:  alu_result = opa_q - opb_q;
      OP_NAND: alu_result = ~(opa_q & opb_q);
      OP_LI:   alu_result = {{(DATA_W-4){imm_q[3]}}, imm_q};
      default: alu_result = '0;
    endcase
  end

`ifdef REGCTL_FLAGS_EN
  // Carry out of an add shows up as a sum smaller than an addend;
  // borrow of a subtract is an unsigned rs < rt.
  logic alu_carry;
  logic carry_q;
  always_comb begin
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD:  alu_carry = (alu_result < opa_q);
      OP_SUB:  alu_carry = (opa_q < opb_q);
      default: alu_carry = 1'b0;
    endcase
  end
`endif

  // Datapath registers. rf_write/done are registered from the next state so
  // they cover the full WRITE cycle and drop immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_ADD;
      imm_q     <= '0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      rf_waddr  <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      rf_write  <= 1'b0;
      done      <= 1'b0;
`ifdef REGCTL_FLAGS_EN
      carry_q   <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
`endif
    end else begin
      rf_write <= (state_next == WRITE);
      done     <= (state_next == WRITE);
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q     <= instr[7:6];
            imm_q    <= instr[5:2];
            rf_waddr <= instr[1:0];
            // LI reads nothing, so the read ports keep their last address
            if (instr[7:6] != OP_LI) begin
              rf_raddr1 <= instr[5:4];
              rf_raddr2 <= instr[3:2];
            end
          end
        end
        READ: begin
          opa_q <= rf_rdata1;
          opb_q <= rf_rdata2;
        end
        EXEC: begin
          result_q <= alu_result;
`ifdef REGCTL_FLAGS_EN
          carry_q  <= alu_carry;
`endif
        end
        WRITE: begin
`ifdef REGCTL_FLAGS_EN
          flag_z <= (result_q == '0);
          if (op_q != OP_LI) flag_c <= carry_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: a simple register-file model answers the DUT's
// reads and takes its writes; a reference model computes every result from
// the instruction semantics and the bench's own copy of the register values.
module tb_regfile_seq_ctrl;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]   instr;
  logic         instr_valid;
  logic         instr_ready;
  logic [1:0]   rf_raddr1, rf_raddr2;
  logic [W-1:0] rf_rdata1, rf_rdata2;
  logic         rf_write;
  logic [1:0]   rf_waddr;
  logic [W-1:0] rf_wdata;
  logic         done;
  logic         busy;
  logic [1:0]   fsm_state;
`ifdef REGCTL_FLAGS_EN
  logic         flag_z, flag_c;
`endif

  regfile_seq_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .busy(busy), .fsm_state(fsm_state)
`ifdef REGCTL_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  // ---------------- register file environment ----------------
  logic [W-1:0] rf [4];
  logic         pre_we = 1'b0;
  logic [1:0]   pre_addr = '0;
  logic [W-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (rf_write === 1'b1) rf[rf_waddr] <= rf_wdata;
    if (pre_we) rf[pre_addr] <= pre_data;
  end
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  int wr_count = 0;
  always @(posedge clk) if (rf_write === 1'b1) wr_count <= wr_count + 1;

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] ref_rf [4];
  logic [1:0]   ref_raddr1 = '0, ref_raddr2 = '0;
  bit           ref_z = 0, ref_c = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [W-1:0] model_result(input int op, input int a, input int b, input int imm);
    int r;
    case (op)
      0:       r = (a + b) % 256;
      1:       r = (a - b + 256) % 256;
      2:       r = 255 - (a & b);
      default: r = (imm >= 8) ? imm + 240 : imm;
    endcase
    return r[W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_reg(input logic [1:0] a, input logic [W-1:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    ref_rf[a] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after WRITE.
  task automatic run_instr(input logic [7:0] ins, input bit keep_valid);
    logic [1:0] op, rs, rt, rd;
    logic [3:0] imm;
    logic [W-1:0] exp_w;
    logic [1:0] exp_a;
    int t, lat, a, b, ires;
    op = ins[7:6]; rs = ins[5:4]; rt = ins[3:2]; rd = ins[1:0]; imm = ins[5:2];
    instr = ins; instr_valid = 1'b1;
    t = 0;
    while (instr_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 20) begin
      n_fail++; $display("FAIL accept_timeout: instr_ready=%b, required 1 within 20 cycles", instr_ready);
      instr_valid = 1'b0;
      return;
    end
    a = int'(ref_rf[rs]); b = int'(ref_rf[rt]);
    exp_w = model_result(int'(op), a, b, int'(imm));
    exp_q.push_back(exp_w);
    exp_addr_q.push_back(rd);
    ires = int'(exp_w);
    ref_z = (ires == 0);
    if (op == 2'd0) ref_c = (a + b) > 255;
    else if (op == 2'd1) ref_c = (a < b);
    else if (op == 2'd2) ref_c = 0;
    ref_rf[rd] = exp_w;
    if (op != 2'd3) begin ref_raddr1 = rs; ref_raddr2 = rt; end
    @(posedge clk); #1;
    if (!keep_valid) instr_valid = 1'b0;
    lat = (op == 2'd3) ? 2 : 3;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || instr_ready !== 1'b0) begin
        n_fail++; $display("FAIL busy_ready cyc%0d: busy=%b ready=%b, required 1/0", k, busy, instr_ready);
      end
      n_checks++;
      if (rf_write !== (k == lat) || done !== (k == lat)) begin
        n_fail++; $display("FAIL write_timing cyc%0d: rf_write=%b done=%b, required %b", k, rf_write, done, (k == lat));
      end
      n_checks++;
      if (rf_raddr1 !== ref_raddr1 || rf_raddr2 !== ref_raddr2) begin
        n_fail++; $display("FAIL raddr cyc%0d: got %0d/%0d, required %0d/%0d", k, rf_raddr1, rf_raddr2, ref_raddr1, ref_raddr2);
      end
      if (k == lat) begin
        exp_w = exp_q.pop_front();
        exp_a = exp_addr_q.pop_front();
        n_checks++;
        if (rf_wdata !== exp_w || rf_waddr !== exp_a) begin
          n_fail++; $display("FAIL writeback instr=%h: addr=%0d data=%h, required addr=%0d data=%h", ins, rf_waddr, rf_wdata, exp_a, exp_w);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0 || rf_write !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL return_idle: ready=%b busy=%b write=%b done=%b, required 1/0/0/0", instr_ready, busy, rf_write, done);
    end
`ifdef REGCTL_FLAGS_EN
    n_checks++;
    if (flag_z !== ref_z || flag_c !== ref_c) begin
      n_fail++; $display("FAIL flags instr=%h: z=%b c=%b, required z=%b c=%b", ins, flag_z, flag_c, ref_z, ref_c);
    end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1; instr = '0; instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rf_write !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rf_raddr1 !== 2'd0 || rf_raddr2 !== 2'd0 ||
        rf_waddr !== 2'd0 || rf_wdata !== '0) begin
      n_fail++; $display("FAIL reset_values: write=%b done=%b busy=%b ra1=%0d ra2=%0d wa=%0d wd=%h, required all 0",
                         rf_write, done, busy, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata);
    end
`ifdef REGCTL_FLAGS_EN
    n_checks++;
    if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: z=%b c=%b, required 0/0", flag_z, flag_c);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: %b, required 1", instr_ready);
    end
    for (int i = 0; i < 4; i++) set_reg(i[1:0], '0);
  endtask

  task automatic test_add;
    set_reg(2'd1, 8'h05);
    set_reg(2'd2, 8'h0A);
    run_instr({2'b00, 2'd1, 2'd2, 2'd3}, 1'b0);   // r3 = 0x0F
  endtask

  task automatic test_li;
    run_instr({2'b11, 4'b1010, 2'd0}, 1'b0);       // r0 = 0xFA
    run_instr({2'b11, 4'b0111, 2'd2}, 1'b0);       // r2 = 0x07
  endtask

  task automatic test_wrap;
    set_reg(2'd2, 8'hFF);
    set_reg(2'd3, 8'h01);
    run_instr({2'b00, 2'd2, 2'd3, 2'd1}, 1'b0);   // r1 = 0x00, z=1 c=1
    set_reg(2'd0, 8'h03);
    set_reg(2'd2, 8'h05);
    run_instr({2'b01, 2'd0, 2'd2, 2'd3}, 1'b0);   // r3 = 0xFE, z=0 c=1
    run_instr({2'b10, 2'd0, 2'd2, 2'd1}, 1'b0);   // r1 = ~(3&5) = 0xFE, c=0
  endtask

  task automatic test_back_to_back;
    int w0;
    w0 = wr_count;
    set_reg(2'd0, 8'h11);
    set_reg(2'd1, 8'h22);
    // valid stays high throughout; the second op depends on the first's rd
    run_instr({2'b00, 2'd0, 2'd1, 2'd2}, 1'b1);   // r2 = 0x33
    run_instr({2'b01, 2'd2, 2'd0, 2'd3}, 1'b0);   // r3 = 0x33 - 0x11
    n_checks++;
    if (wr_count - w0 !== 2) begin
      n_fail++; $display("FAIL write_pulses: %0d, required 2", wr_count - w0);
    end
  endtask

  task automatic test_self_operand;
    set_reg(2'd1, 8'h40);
    run_instr({2'b00, 2'd1, 2'd1, 2'd1}, 1'b0);   // r1 = 0x80
  endtask

  task automatic test_reset_mid_exec;
    int w0;
    set_reg(2'd0, 8'h09);
    set_reg(2'd1, 8'h04);
    w0 = wr_count;
    instr = {2'b01, 2'd0, 2'd1, 2'd2}; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);            // READ
    @(negedge clk);            // EXEC
    reset = 1'b1;
    #1;
    n_checks++;
    if (rf_write !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1 ||
        rf_raddr1 !== 2'd0 || rf_raddr2 !== 2'd0 || rf_waddr !== 2'd0 || rf_wdata !== '0) begin
      n_fail++; $display("FAIL reset_mid_exec: write=%b done=%b busy=%b ready=%b ra1=%0d ra2=%0d wa=%0d wd=%h, required reset values",
                         rf_write, done, busy, instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_count !== w0) begin
      n_fail++; $display("FAIL abandoned_write: %0d writes, required 0", wr_count - w0);
    end
    ref_raddr1 = '0; ref_raddr2 = '0; ref_z = 0; ref_c = 0;
    run_instr({2'b01, 2'd0, 2'd1, 2'd2}, 1'b0);   // r2 = 0x05
  endtask

  task automatic test_random;
    logic [7:0] ins;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) set_reg(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      ins = 8'($urandom_range(0, 255));
      run_instr(ins, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_li();
    test_wrap();
    test_back_to_back();
    test_self_operand();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
